mx_tile_loader: RTL
===================

Name: mx_tile_loader

Overview:
- Upstream staging buffer for the MX attention datapath.
- Accepts MX operand rows (element mantissas plus per-block shared scales) one row per handshake beat.
- Assembles complete ROWS x COLS tiles in a ping-pong buffer and presents each tile as a parallel array, with matching scale array, to the attention core's Q / K^T / V inputs.
- Decouples a streaming producer (DMA or previous layer) from the fully parallel attention inputs; one loader instance per operand.

Parameters:
- ROWS, 4, rows per tile (S_q, d_kq or S_kv depending on operand); ≥2.
- COLS, 8, elements per row; must be a multiple of k.
- k, 2, MX block size (elements sharing one scale).
- BIT_WIDTH, 9, element width (1 + exp_width + man_width), signed.
- scale_width, 8, shared-scale width.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- s_valid_i  in  1  producer row valid.
- s_ready_o  out  1  loader can accept a row.
- s_data_i  in  [COLS] x BIT_WIDTH  row elements, signed.
- s_scale_i  in  [COLS/k] x scale_width  row block scales.
- s_last_i  in  1  producer marks final row of a tile.
- tile_valid_o  out  1  complete tile available.
- tile_ready_i  in  1  consumer accepts tile.
- tile_data_o  out  [ROWS][COLS] x BIT_WIDTH  tile elements.
- tile_scale_o  out  [ROWS][COLS/k] x scale_width  tile scales.
- err_o  out  1  sticky framing error.

Behaviour:
- Clocking/reset: one clock i_clk. Reset is asynchronous, active-low on i_rst_n.
- On reset:
  - both banks EMPTY; wr_bank = rd_bank = 0; row counter = 0.
  - s_ready_o = 1, tile_valid_o = 0, err_o = 0.
  - tile_data_o/tile_scale_o = 0; storage contents need not be cleared.
- Banks: two banks, each with state EMPTY, FILLING or FULL.
- Write side:
  - s_ready_o = (state[wr_bank] != FULL), decoded from registers only; no combinational path from s_valid_i.
  - Accept = s_valid_i & s_ready_o.
  - On accept, row at counter index is written, counter increments, bank goes EMPTY→FILLING.
  - When accepting row ROWS-1: bank → FULL, counter → 0, wr_bank toggles.
- Read side:
  - tile_valid_o = (state[rd_bank] == FULL).
  - tile_data_o/tile_scale_o show rd_bank contents and stay stable while tile_valid_o is high.
  - On tile_valid_o & tile_ready_i: rd_bank → EMPTY, rd_bank toggles.
- Latency:
  - tile_valid_o rises the cycle after the final row is accepted.
  - Sustained throughput is one row per cycle with no bubbles between tiles while the consumer keeps up.
- Both banks FULL:
  - s_ready_o = 0.
  - A consumer accept in cycle t releases a bank; s_ready_o = 1 in cycle t+1.
- Simultaneous write-complete and read-accept on different banks are independent; both take effect.
- Framing:
  - s_last_i on a row index < ROWS-1: err_o set, that row is dropped, the partial bank is discarded (→ EMPTY, counter → 0, wr_bank unchanged).
  - s_last_i = 0 on row ROWS-1: err_o set, but the tile completes normally.
  - err_o clears only on reset.
- Reset mid-operation: all tiles in flight are lost; outputs return to reset values asynchronously.
- No arithmetic on data: elements and scales are stored bit-exact; scale order within a row is preserved (scale j covers elements j·k … j·k+k-1).

Decomposition:
- Shared package mx_loader_pkg:
  - bank_state_t enum {EMPTY, FILLING, FULL}.
  - localparam ROW_IDX_W = $clog2(ROWS).
  - Typedefs for the element and scale vectors, parameterised via the module.
- One sub-module, mx_tile_bank: storage for one bank, with row write-enable/index in and parallel read out. Instantiated twice.
- Bank control FSM and pointers stay in mx_tile_loader.

Test Plan:
- Single tile: 4 rows with data = row·8+col and scales = row·4+blk, s_last on row 3, tile_ready_i=1 → tile_valid_o rises 1 cycle after row 3; tile_data_o[2][5] = 21; tile_scale_o[3][1] = 13; err_o = 0.
- Back-pressure: stream 3 tiles (12 beats, valid held high) with tile_ready_i=0 → s_ready_o drops after beat 8. Raise tile_ready_i for 1 cycle → s_ready_o = 1 the next cycle; tiles emerge in order 0, 1, 2.
- Full throughput: continuous rows with tile_ready_i=1 → a new tile every 4 cycles; s_ready_o never deasserts.
- Early last: s_last_i on row 1 → err_o = 1; the next 4 correct rows form a valid tile containing only those rows.
- Missing last: no s_last_i on row 3 → tile delivered intact, err_o = 1.
- Reset mid-fill: i_rst_n low after 2 rows with no clock edge → outputs reset immediately; after release, a fresh 4-row tile is delivered correctly.

Source files
------------

// File: rtl/mx_loader_pkg.sv
// Shared definitions for the MX tile loader.
// Holds the default tile geometry, the bank state encoding and a helper for
// sizing the row counter. Vector typedefs live in the modules, where the
// actual parameter values are known.
package mx_loader_pkg;

   localparam int unsigned DEF_ROWS        = 4;
   localparam int unsigned DEF_COLS        = 8;
   localparam int unsigned DEF_K           = 2;
   localparam int unsigned DEF_BIT_WIDTH   = 9;
   localparam int unsigned DEF_SCALE_WIDTH = 8;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_state_t;

   // Row counter width; never zero so a 1-row index still has a bit.
   function automatic int unsigned row_idx_w(input int unsigned rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

   localparam int unsigned ROW_IDX_W = row_idx_w(DEF_ROWS);

endpackage

// File: rtl/mx_tile_loader_if.sv
// Row-stream in / tile out bundle for mx_tile_loader.
//   s_*    : producer row handshake (elements, block scales, last-row marker)
//   tile_* : parallel tile handshake towards the attention core
//   err_o  : sticky framing error
// Modports: slave = the loader, master = producer/consumer side.
interface mx_tile_loader_if
   import mx_loader_pkg::*;
#(
   parameter int unsigned ROWS        = DEF_ROWS,
   parameter int unsigned COLS        = DEF_COLS,
   parameter int unsigned K           = DEF_K,
   parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
   parameter int unsigned SCALE_WIDTH = DEF_SCALE_WIDTH
);
   localparam int unsigned NBLK = COLS / K;

   logic                                         s_valid_i;
   logic                                         s_ready_o;
   logic [COLS-1:0][BIT_WIDTH-1:0]               s_data_i;
   logic [NBLK-1:0][SCALE_WIDTH-1:0]             s_scale_i;
   logic                                         s_last_i;
   logic                                         tile_valid_o;
   logic                                         tile_ready_i;
   logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0]     tile_data_o;
   logic [ROWS-1:0][NBLK-1:0][SCALE_WIDTH-1:0]   tile_scale_o;
   logic                                         err_o;

   modport slave (
      input  s_valid_i, s_data_i, s_scale_i, s_last_i, tile_ready_i,
      output s_ready_o, tile_valid_o, tile_data_o, tile_scale_o, err_o
   );

   modport master (
      output s_valid_i, s_data_i, s_scale_i, s_last_i, tile_ready_i,
      input  s_ready_o, tile_valid_o, tile_data_o, tile_scale_o, err_o
   );

endinterface

// File: rtl/mx_tile_bank.sv
// One tile bank: ROWS rows of element and scale storage.
//   clk_i            : clock
//   we_i, row_i      : write strobe and row index
//   data_i, scale_i  : row to store
//   data_o, scale_o  : whole bank, read in parallel
// Storage is deliberately not reset; the loader masks it until the bank is FULL.
module mx_tile_bank #(
   parameter int unsigned ROWS        = 4,
   parameter int unsigned COLS        = 8,
   parameter int unsigned NBLK        = 4,
   parameter int unsigned BIT_WIDTH   = 9,
   parameter int unsigned SCALE_WIDTH = 8,
   parameter int unsigned ROW_W       = 2
) (
   input  logic                                       clk_i,
   input  logic                                       we_i,
   input  logic [ROW_W-1:0]                           row_i,
   input  logic [COLS-1:0][BIT_WIDTH-1:0]             data_i,
   input  logic [NBLK-1:0][SCALE_WIDTH-1:0]           scale_i,
   output logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0]   data_o,
   output logic [ROWS-1:0][NBLK-1:0][SCALE_WIDTH-1:0] scale_o
);

   logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0]   data_q;
   logic [ROWS-1:0][NBLK-1:0][SCALE_WIDTH-1:0] scale_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         data_q[row_i]  <= data_i;
         scale_q[row_i] <= scale_i;
      end
   end

   assign data_o  = data_q;
   assign scale_o = scale_q;

endmodule

// File: rtl/mx_tile_loader.sv
// Ping-pong tile assembler for one MX attention operand.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : row stream in, parallel tile + scales out, sticky err_o
// Rows fill the write bank; a full bank is presented on the tile outputs until
// the consumer takes it. Ready is decoded from registered bank state only.
module mx_tile_loader
   import mx_loader_pkg::*;
#(
   parameter int unsigned ROWS        = DEF_ROWS,
   parameter int unsigned COLS        = DEF_COLS,
   parameter int unsigned K           = DEF_K,
   parameter int unsigned BIT_WIDTH   = DEF_BIT_WIDTH,
   parameter int unsigned SCALE_WIDTH = DEF_SCALE_WIDTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   mx_tile_loader_if.slave      bus
);

   localparam int unsigned NBLK    = COLS / K;
   localparam int unsigned RowIdxW = row_idx_w(ROWS);
   localparam logic [RowIdxW-1:0] LastRow = RowIdxW'(ROWS - 1);

   typedef logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0]   tile_data_t;
   typedef logic [ROWS-1:0][NBLK-1:0][SCALE_WIDTH-1:0] tile_scale_t;

   bank_state_t        bank_state_q [2];
   bank_state_t        bank_state_d [2];
   logic               wr_bank_q, wr_bank_d;
   logic               rd_bank_q, rd_bank_d;
   logic [RowIdxW-1:0] row_cnt_q, row_cnt_d;
   logic               err_q, err_d;

   logic        [1:0] bank_we;
   tile_data_t        bank_data  [2];
   tile_scale_t       bank_scale [2];

   logic s_ready, tile_valid, s_accept, tile_fire, row_last;

   assign s_ready    = (bank_state_q[wr_bank_q] != FULL);
   assign tile_valid = (bank_state_q[rd_bank_q] == FULL);
   assign s_accept   = bus.s_valid_i & s_ready;
   assign tile_fire  = tile_valid & bus.tile_ready_i;
   assign row_last   = (row_cnt_q == LastRow);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      mx_tile_bank #(
         .ROWS        (ROWS),
         .COLS        (COLS),
         .NBLK        (NBLK),
         .BIT_WIDTH   (BIT_WIDTH),
         .SCALE_WIDTH (SCALE_WIDTH),
         .ROW_W       (RowIdxW)
      ) u_bank (
         .clk_i   (i_clk),
         .we_i    (bank_we[b]),
         .row_i   (row_cnt_q),
         .data_i  (bus.s_data_i),
         .scale_i (bus.s_scale_i),
         .data_o  (bank_data[b]),
         .scale_o (bank_scale[b])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bank_state_q[0] <= EMPTY;
         bank_state_q[1] <= EMPTY;
         wr_bank_q       <= 1'b0;
         rd_bank_q       <= 1'b0;
         row_cnt_q       <= '0;
         err_q           <= 1'b0;
      end else begin
         bank_state_q <= bank_state_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         row_cnt_q    <= row_cnt_d;
         err_q        <= err_d;
      end
   end

   // A write only targets a non-FULL bank and a read only a FULL one, so when
   // both fire in one cycle they touch different banks and never collide.
   always_comb begin
      bank_state_d = bank_state_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      row_cnt_d    = row_cnt_q;
      err_d        = err_q;
      bank_we      = '0;

      if (s_accept) begin
         if (bus.s_last_i && !row_last) begin
            // Early last: drop the row and throw away the partial tile.
            err_d                   = 1'b1;
            bank_state_d[wr_bank_q] = EMPTY;
            row_cnt_d               = '0;
         end else begin
            bank_we[wr_bank_q] = 1'b1;
            if (row_last) begin
               bank_state_d[wr_bank_q] = FULL;
               row_cnt_d               = '0;
               wr_bank_d               = ~wr_bank_q;
               if (!bus.s_last_i) begin
                  err_d = 1'b1;
               end
            end else begin
               bank_state_d[wr_bank_q] = FILLING;
               row_cnt_d               = row_cnt_q + 1'b1;
            end
         end
      end

      if (tile_fire) begin
         bank_state_d[rd_bank_q] = EMPTY;
         rd_bank_d               = ~rd_bank_q;
      end
   end

   assign bus.s_ready_o    = s_ready;
   assign bus.tile_valid_o = tile_valid;
   assign bus.err_o        = err_q;
   // Gating with valid yields zeros after reset without clearing storage.
   assign bus.tile_data_o  = tile_valid ? bank_data[rd_bank_q]  : '0;
   assign bus.tile_scale_o = tile_valid ? bank_scale[rd_bank_q] : '0;

endmodule
